// File: rtl/instruction_fetch_stage_pkg.sv
// rtl/instruction_fetch_stage_pkg.sv - shared types and constants for the IF stage
package instruction_fetch_stage_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  // REQ: asking for PC; WAIT: response pending; WAIT_KILL: pending response is stale;
  // HOLD: response parked in the skid behind a stalled IF/ID
  typedef enum logic [1:0] {
    ST_REQ       = 2'd0,
    ST_WAIT      = 2'd1,
    ST_WAIT_KILL = 2'd2,
    ST_HOLD      = 2'd3
  } fetch_state_t;

  // Sequential PC, wraps modulo 2^32
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Branch targets are forced onto a word boundary
  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return pc & ~32'd3;
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_skid_buffer.sv
// rtl/instruction_fetch_stage_skid_buffer.sv - one-entry parking slot for a fetched instruction
module fetch_skid_buffer
  import instruction_fetch_stage_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_i,
  input  logic               rd_i,
  input  logic               clr_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [31:0]        pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        pc_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [31:0]        pc_q;

  // Clear beats write beats read; data is only captured on write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= 32'd0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (wr_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (rd_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - RV32I fetch stage: PC, imem request FSM and IF/ID register
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               Clk_i,
  input  logic               Rst_i,
  output logic               Imem_req_o,
  output logic [31:0]        Imem_addr_o,
  input  logic               Imem_gnt_i,
  input  logic               Imem_rvalid_i,
  input  logic [INSTR_W-1:0] Imem_rdata_i,
  input  logic               Stall_i,
  input  logic               Flush_i,
  input  logic               Redirect_i,
  input  logic [31:0]        Redirect_pc_i,
  output logic [INSTR_W-1:0] Instruction_o,
  output logic [31:0]        Pc_o,
  output logic [31:0]        Pc_plus4_o,
  output logic               Valid_o
);

  fetch_state_t       state_q;
  logic [31:0]        pc_q;
  logic [31:0]        fetch_pc_q;

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [31:0]        pc_out_q;
  logic [31:0]        pc4_q;

  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [31:0]        skid_pc;

  logic               can_accept;
  logic               resp_kill;
  logic               resp_load;
  logic               resp_park;
  logic               skid_load;
  logic               skid_clr;
  logic               req;
  logic               fire;

  // IF/ID can take a new word if it is empty or about to be consumed
  assign can_accept = !valid_q || !Stall_i;
  // A response arriving together with a flush or redirect belongs to the old path
  assign resp_kill  = Flush_i || Redirect_i;
  assign resp_load  = (state_q == ST_WAIT) && Imem_rvalid_i && !resp_kill && can_accept;
  assign resp_park  = (state_q == ST_WAIT) && Imem_rvalid_i && !resp_kill && !can_accept;
  assign skid_load  = (state_q == ST_HOLD) && skid_valid && !Stall_i && !resp_kill;
  assign skid_clr   = Flush_i || ((state_q == ST_HOLD) && Redirect_i);
  assign fire       = req && Imem_gnt_i;

  // Request is Mealy in WAIT so back-to-back fetches sustain one per cycle
  always_comb begin
    req = 1'b0;
    if (!Rst_i) begin
      case (state_q)
        ST_REQ:  req = 1'b1;
        ST_WAIT: req = resp_load;
        default: req = 1'b0;
      endcase
    end
  end

  assign Imem_req_o  = req;
  assign Imem_addr_o = pc_q;

  // Fetch FSM and PC; a redirect always has the final say over the PC
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      if (fire) begin
        fetch_pc_q <= pc_q;
        pc_q       <= pc_inc(pc_q);
      end
      if (Redirect_i) begin
        pc_q <= pc_align(Redirect_pc_i);
      end
      case (state_q)
        ST_REQ: begin
          if (Imem_gnt_i) begin
            state_q <= Redirect_i ? ST_WAIT_KILL : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (Imem_rvalid_i) begin
            if (resp_park) begin
              state_q <= ST_HOLD;
            end else if (!fire) begin
              state_q <= ST_REQ;
            end
          end else if (Redirect_i) begin
            state_q <= ST_WAIT_KILL;
          end
        end
        ST_HOLD: begin
          if (resp_kill || !Stall_i) begin
            state_q <= ST_REQ;
          end
        end
        ST_WAIT_KILL: begin
          if (Imem_rvalid_i) begin
            state_q <= ST_REQ;
          end
        end
        default: state_q <= ST_REQ;
      endcase
    end
  end

  // IF/ID register: flush over load over stall-hold; otherwise drain to a bubble
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      valid_q  <= 1'b0;
      instr_q  <= NOP_INSTR;
      pc_out_q <= RESET_PC;
      pc4_q    <= pc_inc(RESET_PC);
    end else if (Flush_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (resp_load) begin
      valid_q  <= 1'b1;
      instr_q  <= Imem_rdata_i;
      pc_out_q <= fetch_pc_q;
      pc4_q    <= pc_inc(fetch_pc_q);
    end else if (skid_load) begin
      valid_q  <= 1'b1;
      instr_q  <= skid_instr;
      pc_out_q <= skid_pc;
      pc4_q    <= pc_inc(skid_pc);
    end else if (!Stall_i) begin
      valid_q <= 1'b0;
    end
  end

  fetch_skid_buffer u_skid (
    .clk_i   (Clk_i),
    .rst_i   (Rst_i),
    .wr_i    (resp_park),
    .rd_i    (skid_load),
    .clr_i   (skid_clr),
    .instr_i (Imem_rdata_i),
    .pc_i    (fetch_pc_q),
    .valid_o (skid_valid),
    .instr_o (skid_instr),
    .pc_o    (skid_pc)
  );

  assign Instruction_o = instr_q;
  assign Pc_o          = pc_out_q;
  assign Pc_plus4_o    = pc4_q;
  assign Valid_o       = valid_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - randomized bench for the fetch stage with an instruction-stream model
module tb_instruction_fetch_stage;
  import instruction_fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, gnt, rvalid;
  logic [31:0] addr, rdata;
  logic        stall, flush, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr, pc, pc4;
  logic        valid;

  always #5 clk = ~clk;

  instruction_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .Clk_i         (clk),
    .Rst_i         (rst),
    .Imem_req_o    (req),
    .Imem_addr_o   (addr),
    .Imem_gnt_i    (gnt),
    .Imem_rvalid_i (rvalid),
    .Imem_rdata_i  (rdata),
    .Stall_i       (stall),
    .Flush_i       (flush),
    .Redirect_i    (redirect),
    .Redirect_pc_i (redirect_pc),
    .Instruction_o (instr),
    .Pc_o          (pc),
    .Pc_plus4_o    (pc4),
    .Valid_o       (valid)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Contents of instruction memory: a fixed scramble of the word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
  endfunction

  // Memory model: at most one pending response
  bit          out_valid;
  int          out_wait;
  logic [31:0] out_addr;

  // Program-order model: the next PC that must appear as a fresh IF/ID entry
  logic [31:0] exp_pc;
  int          delivered;
  bit          saw_wrap;
  logic [31:0] target;

  bit          prev_valid, prev_stall, prev_flush, prev_redirect, prev_req, prev_gnt, prev_rst;
  logic [31:0] prev_addr, prev_pc, prev_instr, prev_target;

  initial begin
    rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    out_valid = 0; out_wait = 0; out_addr = 0;
    exp_pc = 32'h0; delivered = 0; saw_wrap = 0; target = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req", req, 1'b0);
    check_eq("rst_valid", valid, 1'b0);
    check_eq("rst_instr", instr, 32'h0000_0013);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_pc4", pc4, 32'h4);

    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rel_req", req, 1'b1);
    check_eq("rel_addr", addr, 32'h0);
    check_eq("rel_valid", valid, 1'b0);
    prev_valid = 0; prev_stall = 0; prev_flush = 0; prev_redirect = 0;
    prev_req = req; prev_gnt = 0; prev_rst = 0; prev_addr = addr;
    prev_pc = pc; prev_instr = instr; prev_target = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      rst = (cyc == 2000 || cyc == 2001);
      rvalid = 1'b0;
      rdata  = $urandom();
      if (rst) begin
        out_valid = 0;
      end else if (out_valid) begin
        out_wait--;
        if (out_wait == 0) begin
          rvalid = 1'b1;
          rdata  = mem_word(out_addr);
        end
      end
      gnt = ($urandom_range(0, 9) < 7);
      if (cyc >= 600 && cyc < 606) gnt = 1'b0;
      stall = ($urandom_range(0, 3) == 0);
      redirect = 1'b0;
      flush = 1'b0;
      if (cyc == 300) begin
        redirect = 1'b1; flush = 1'b1; target = 32'hFFFF_FFF8;
      end else if (cyc == 600) begin
        redirect = 1'b1; flush = 1'b1; target = 32'h0000_0103;
      end else if (!(cyc > 300 && cyc < 340) && !(cyc > 600 && cyc < 610)) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 3) begin
          redirect = 1'b1; flush = 1'b1; target = $urandom();
        end else if (r == 3) begin
          redirect = 1'b1; target = $urandom();
        end
      end
      if (cyc >= 300 && cyc < 340) stall = 1'b0;
      if (rst) begin
        stall = 1'b0; redirect = 1'b0; flush = 1'b0;
      end
      redirect_pc = target;

      @(negedge clk);

      // Request-side protocol
      if (rst) begin
        check_eq("req_in_reset", req, 1'b0);
      end else begin
        if (req) check_eq("addr_align", addr & 32'h3, 32'h0);
        if (out_valid && !rvalid) check_eq("req_while_pending", req, 1'b0);
        if (prev_rst) begin
          check_eq("post_rst_req", req, 1'b1);
          check_eq("post_rst_addr", addr, 32'h0);
        end else if (prev_req && !prev_gnt && !prev_redirect) begin
          check_eq("req_held", req, 1'b1);
          check_eq("addr_stable", addr, prev_addr);
        end
        if (prev_redirect && req) check_eq("redirect_addr", addr, prev_target & ~32'h3);
      end

      // IF/ID stream
      if (prev_flush) begin
        check_eq("flush_valid", valid, 1'b0);
        check_eq("flush_instr", instr, 32'h0000_0013);
      end else if (prev_valid && prev_stall) begin
        check_eq("hold_valid", valid, 1'b1);
        check_eq("hold_pc", pc, prev_pc);
        check_eq("hold_instr", instr, prev_instr);
      end else if (valid) begin
        check_eq("seq_pc", pc, exp_pc);
        check_eq("seq_instr", instr, mem_word(exp_pc));
        check_eq("seq_pc4", pc4, exp_pc + 32'd4);
        if (exp_pc == 32'hFFFF_FFFC) saw_wrap = 1;
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (redirect) exp_pc = target & ~32'h3;
      if (rst) exp_pc = 32'h0;

      // Memory bookkeeping
      if (!rst) begin
        if (rvalid) out_valid = 0;
        if (req && gnt) begin
          out_valid = 1;
          out_wait  = $urandom_range(1, 3);
          out_addr  = addr;
        end
      end

      prev_valid    = valid;
      prev_stall    = stall;
      prev_flush    = flush || rst;
      prev_redirect = redirect;
      prev_req      = rst ? 1'b0 : req;
      prev_gnt      = gnt;
      prev_rst      = rst;
      prev_addr     = addr;
      prev_pc       = pc;
      prev_instr    = instr;
      prev_target   = target;
    end

    check_eq("wrap_seen", saw_wrap, 1'b1);
    check_eq("throughput", (delivered > 300), 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
